ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/ram_arbiter_rr_pick2.sv | 24 ++
 rtl/ram_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for the two-master RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    OWN0  = 2'd2,
    OWN1  = 2'd3
  } arb_state_t;

  typedef logic master_id_t;

  function automatic arb_state_t own_state(input master_id_t id);
    return (id == 1'b1) ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin picker: the master not granted last wins a tie.
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  master_id_t i_last,
  output logic       o_valid,
  output master_id_t o_winner
);

  master_id_t w_pref;

  assign w_pref  = ~i_last;
  assign o_valid = |i_req;

  always_comb begin
    if (i_req[w_pref]) begin
      o_winner = w_pref;
    end else begin
      o_winner = i_last;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter for one single-port RAM with burst-limited round-robin.
// Defining RAM_ARB_CLEAR_EN adds a full-RAM zero sweep (CLEAR state, clear_start, busy).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int REGISTER_COUNT = 256,
  parameter int MAX_BURST      = 4
) (
  input  logic                              cpu_clk,
  input  logic                              reset,
  input  logic                              clear_start,
  input  logic                              m0_req,
  input  logic                              m1_req,
  input  logic [$clog2(REGISTER_COUNT)-1:0] m0_addr,
  input  logic [$clog2(REGISTER_COUNT)-1:0] m1_addr,
  input  logic [WIDTH-1:0]                  m0_wdata,
  input  logic [WIDTH-1:0]                  m1_wdata,
  input  logic                              m0_we,
  input  logic                              m1_we,
  output logic                              m0_gnt,
  output logic                              m1_gnt,
  output logic [WIDTH-1:0]                  m0_rdata,
  output logic [WIDTH-1:0]                  m1_rdata,
  output logic [$clog2(REGISTER_COUNT)-1:0] ram_addr,
  output logic [WIDTH-1:0]                  ram_wdata,
  output logic                              ram_we,
  input  logic [WIDTH-1:0]                  ram_rdata,
  output logic                              busy
);

  localparam int AW = $clog2(REGISTER_COUNT);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  arb_state_t     r_state;
  logic [BW-1:0]  r_burst_cnt;
  master_id_t     r_last_gnt;
  logic [AW-1:0]  w_sweep_addr;
  logic           w_sweep_done;
  logic           w_clear_req;
  logic           w_owner_req;
  logic           w_keep;
  logic           w_pick_valid;
  master_id_t     w_pick_winner;

`ifdef RAM_ARB_CLEAR_EN
  localparam arb_state_t RESET_STATE = CLEAR;
  localparam logic [AW-1:0] SWEEP_LAST = AW'(REGISTER_COUNT - 1);
  logic [AW-1:0] r_sweep_cnt;

  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      r_sweep_cnt <= '0;
    end else if (r_state == CLEAR && r_sweep_cnt != SWEEP_LAST) begin
      r_sweep_cnt <= r_sweep_cnt + 1'b1;
    end else begin
      r_sweep_cnt <= '0;
    end
  end

  assign w_sweep_addr = r_sweep_cnt;
  assign w_sweep_done = (r_sweep_cnt == SWEEP_LAST);
  assign w_clear_req  = clear_start;
  assign busy         = (r_state == CLEAR);
`else
  localparam arb_state_t RESET_STATE = IDLE;
  logic w_unused_clear;

  assign w_unused_clear = clear_start;
  assign w_sweep_addr   = '0;
  assign w_sweep_done   = 1'b1;
  assign w_clear_req    = 1'b0;
  assign busy           = 1'b0;
`endif

  rr_pick2 u_pick (
    .i_req    ({m1_req, m0_req}),
    .i_last   (r_last_gnt),
    .o_valid  (w_pick_valid),
    .o_winner (w_pick_winner)
  );

  assign w_owner_req = (r_state == OWN0) ? m0_req : ((r_state == OWN1) ? m1_req : 1'b0);
  assign w_keep      = w_owner_req && (r_burst_cnt < BURST_LAST);

  // last-grant resets to master 1 so that master 0 wins the first tie
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      r_state     <= RESET_STATE;
      r_burst_cnt <= '0;
      r_last_gnt  <= 1'b1;
    end else begin
      case (r_state)
        CLEAR: begin
          if (w_sweep_done) begin
            r_state <= IDLE;
          end
        end
        IDLE, OWN0, OWN1: begin
          if (w_clear_req) begin
            r_state     <= CLEAR;
            r_burst_cnt <= '0;
          end else if (w_keep) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
          end else if (w_pick_valid) begin
            r_state     <= own_state(w_pick_winner);
            r_last_gnt  <= w_pick_winner;
            r_burst_cnt <= '0;
          end else begin
            r_state     <= IDLE;
            r_burst_cnt <= '0;
          end
        end
        default: r_state <= RESET_STATE;
      endcase
    end
  end

  // ram_we is gated by reset so the sweep write cannot leak while reset is held
  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    case (r_state)
      CLEAR: begin
        ram_addr = w_sweep_addr;
        ram_we   = ~reset;
      end
      OWN0: begin
        m0_gnt    = m0_req;
        ram_addr  = m0_addr;
        ram_wdata = m0_wdata;
        ram_we    = m0_we & m0_req;
      end
      OWN1: begin
        m1_gnt    = m1_req;
        ram_addr  = m1_addr;
        ram_wdata = m1_wdata;
        ram_we    = m1_we & m1_req;
      end
      default: begin
        ram_we = 1'b0;
      end
    endcase
  end

  assign m0_rdata = m0_gnt ? ram_rdata : '0;
  assign m1_rdata = m1_gnt ? ram_rdata : '0;

endmodule
